// File: rtl/incoming_ctx_pipe_if.sv
// ACK-event request stream and retransmit/timer result stream for incoming_ctx_pipe.
// The master drives ACK events and result ready; the slave is the pipeline.
interface incoming_ctx_pipe_if #(
  parameter int FLOW_ID_W = 4,
  parameter int SEQ_W     = 32,
  parameter int TIMER_W   = 32
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [FLOW_ID_W-1:0] in_flow_id;
  logic [SEQ_W-1:0]     in_cum_ack;

  logic                 out_valid;
  logic                 out_ready;
  logic [FLOW_ID_W-1:0] out_flow_id;
  logic                 out_mark_rtx;
  logic                 out_reset_rtx_timer;
  logic [SEQ_W-1:0]     out_rtx_start;
  logic [SEQ_W-1:0]     out_rtx_end;
  logic [TIMER_W-1:0]   out_timer;

  modport master (
    output in_valid, in_flow_id, in_cum_ack, out_ready,
    input  in_ready, out_valid, out_flow_id, out_mark_rtx, out_reset_rtx_timer,
           out_rtx_start, out_rtx_end, out_timer
  );

  modport slave (
    input  in_valid, in_flow_id, in_cum_ack, out_ready,
    output in_ready, out_valid, out_flow_id, out_mark_rtx, out_reset_rtx_timer,
           out_rtx_start, out_rtx_end, out_timer
  );
endinterface

// File: rtl/incoming_ctx_pipe.sv
// Per-flow ACK context pipeline: store read with write forwarding, cumulative-ACK
// window advance, user-logic hookup, store writeback and a stallable result register.
module incoming_ctx_pipe #(
  parameter int               FLOW_CNT  = 16,
  parameter int               FLOW_ID_W = 4,
  parameter int               SEQ_W     = 32,
  parameter int               WIN_W     = 9,
  parameter int               TIMER_W   = 32,
  parameter int               CTX_W     = 36,
  parameter int               INIT_WND  = 1,
  parameter logic [CTX_W-1:0] INIT_CTX  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  incoming_ctx_pipe_if.slave   bus,

  input  logic                 cfg_we,
  input  logic [FLOW_ID_W-1:0] cfg_flow_id,
  input  logic [SEQ_W-1:0]     cfg_wnd_start,
  input  logic [WIN_W-1:0]     cfg_wnd_size,
  input  logic [TIMER_W-1:0]   cfg_timer,
  input  logic [CTX_W-1:0]     cfg_ctx,

  output logic [SEQ_W-1:0]     ul_cum_ack,
  output logic [SEQ_W-1:0]     ul_old_wnd_start,
  output logic [SEQ_W-1:0]     ul_wnd_start,
  output logic [WIN_W-1:0]     ul_new_c_acks_cnt,
  output logic [WIN_W-1:0]     ul_wnd_size,
  output logic [TIMER_W-1:0]   ul_timer,
  output logic [CTX_W-1:0]     ul_ctx,
  input  logic                 ul_mark_rtx,
  input  logic                 ul_reset_rtx_timer,
  input  logic [SEQ_W-1:0]     ul_rtx_start,
  input  logic [SEQ_W-1:0]     ul_rtx_end,
  input  logic [WIN_W-1:0]     ul_wnd_size_out,
  input  logic [TIMER_W-1:0]   ul_timer_out,
  input  logic [CTX_W-1:0]     ul_ctx_out,

  output logic [15:0]          stale_cnt
);

  logic [SEQ_W-1:0]     st_start_q [FLOW_CNT];
  logic [WIN_W-1:0]     st_size_q  [FLOW_CNT];
  logic [TIMER_W-1:0]   st_timer_q [FLOW_CNT];
  logic [CTX_W-1:0]     st_ctx_q   [FLOW_CNT];

  logic                 s1_vld_q;
  logic [FLOW_ID_W-1:0] s1_flow_q;
  logic [SEQ_W-1:0]     s1_ack_q;
  logic [SEQ_W-1:0]     s1_start_q;
  logic [WIN_W-1:0]     s1_size_q;
  logic [TIMER_W-1:0]   s1_timer_q;
  logic [CTX_W-1:0]     s1_ctx_q;

  logic                 out_valid_q;
  logic [FLOW_ID_W-1:0] out_flow_q;
  logic                 out_mark_q;
  logic                 out_rst_tmr_q;
  logic [SEQ_W-1:0]     out_rtx_start_q;
  logic [SEQ_W-1:0]     out_rtx_end_q;
  logic [TIMER_W-1:0]   out_timer_q;

  logic [15:0]          stale_q;
  logic [15:0]          stale_d;

  logic                 stall;
  logic                 accept;
  logic                 s1_wr;

  logic [SEQ_W-1:0]     diff;
  logic                 ahead;
  logic                 in_win;
  logic                 advance;
  logic [SEQ_W-1:0]     new_start;
  logic [WIN_W-1:0]     new_cnt;

  logic [SEQ_W-1:0]     rd_start_d;
  logic [WIN_W-1:0]     rd_size_d;
  logic [TIMER_W-1:0]   rd_timer_d;
  logic [CTX_W-1:0]     rd_ctx_d;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & ~stall;
  assign s1_wr        = s1_vld_q & ~stall;

  // S1 window advance
  assign diff      = s1_ack_q - s1_start_q;
  assign ahead     = s1_ack_q > s1_start_q;
  assign in_win    = diff <= {{(SEQ_W-WIN_W){1'b0}}, s1_size_q};
  assign advance   = ahead & in_win;
  assign new_start = advance ? s1_ack_q : s1_start_q;
  assign new_cnt   = advance ? diff[WIN_W-1:0] : '0;

  assign ul_cum_ack        = s1_ack_q;
  assign ul_old_wnd_start  = s1_start_q;
  assign ul_wnd_start      = new_start;
  assign ul_new_c_acks_cnt = new_cnt;
  assign ul_wnd_size       = s1_size_q;
  assign ul_timer          = s1_timer_q;
  assign ul_ctx            = s1_ctx_q;

  // Same-cycle writes to the requested flow bypass the array; cfg wins over S1.
  always_comb begin
    rd_start_d = st_start_q[bus.in_flow_id];
    rd_size_d  = st_size_q[bus.in_flow_id];
    rd_timer_d = st_timer_q[bus.in_flow_id];
    rd_ctx_d   = st_ctx_q[bus.in_flow_id];
    if (s1_wr && (s1_flow_q == bus.in_flow_id)) begin
      rd_start_d = new_start;
      rd_size_d  = ul_wnd_size_out;
      rd_timer_d = ul_timer_out;
      rd_ctx_d   = ul_ctx_out;
    end
    if (cfg_we && (cfg_flow_id == bus.in_flow_id)) begin
      rd_start_d = cfg_wnd_start;
      rd_size_d  = cfg_wnd_size;
      rd_timer_d = cfg_timer;
      rd_ctx_d   = cfg_ctx;
    end
  end

  always_comb begin
    stale_d = stale_q;
    if (s1_wr && ahead && !in_win && (stale_q != 16'hFFFF)) stale_d = stale_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
        st_start_q[i] <= '0;
        st_size_q[i]  <= WIN_W'(INIT_WND);
        st_timer_q[i] <= '0;
        st_ctx_q[i]   <= INIT_CTX;
      end
    end else begin
      if (s1_wr) begin
        st_start_q[s1_flow_q] <= new_start;
        st_size_q[s1_flow_q]  <= ul_wnd_size_out;
        st_timer_q[s1_flow_q] <= ul_timer_out;
        st_ctx_q[s1_flow_q]   <= ul_ctx_out;
      end
      if (cfg_we) begin
        st_start_q[cfg_flow_id] <= cfg_wnd_start;
        st_size_q[cfg_flow_id]  <= cfg_wnd_size;
        st_timer_q[cfg_flow_id] <= cfg_timer;
        st_ctx_q[cfg_flow_id]   <= cfg_ctx;
      end
    end
  end

  // Stage A -> S1 capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_flow_q  <= '0;
      s1_ack_q   <= '0;
      s1_start_q <= '0;
      s1_size_q  <= '0;
      s1_timer_q <= '0;
      s1_ctx_q   <= '0;
    end else if (!stall) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_flow_q  <= bus.in_flow_id;
        s1_ack_q   <= bus.in_cum_ack;
        s1_start_q <= rd_start_d;
        s1_size_q  <= rd_size_d;
        s1_timer_q <= rd_timer_d;
        s1_ctx_q   <= rd_ctx_d;
      end
    end
  end

  // S1 -> result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_flow_q      <= '0;
      out_mark_q      <= 1'b0;
      out_rst_tmr_q   <= 1'b0;
      out_rtx_start_q <= '0;
      out_rtx_end_q   <= '0;
      out_timer_q     <= '0;
      stale_q         <= '0;
    end else begin
      stale_q <= stale_d;
      if (!stall) begin
        out_valid_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_flow_q      <= s1_flow_q;
          out_mark_q      <= ul_mark_rtx;
          out_rst_tmr_q   <= ul_reset_rtx_timer;
          out_rtx_start_q <= ul_rtx_start;
          out_rtx_end_q   <= ul_rtx_end;
          out_timer_q     <= ul_timer_out;
        end
      end
    end
  end

  assign bus.out_valid           = out_valid_q;
  assign bus.out_flow_id         = out_flow_q;
  assign bus.out_mark_rtx        = out_mark_q;
  assign bus.out_reset_rtx_timer = out_rst_tmr_q;
  assign bus.out_rtx_start       = out_rtx_start_q;
  assign bus.out_rtx_end         = out_rtx_end_q;
  assign bus.out_timer           = out_timer_q;
  assign stale_cnt               = stale_q;

endmodule

// File: tb/tb_incoming_ctx_pipe.sv
// Directed bench for incoming_ctx_pipe with a stub Reno user logic, a sequential
// reference model of the flow store and a per-cycle result scoreboard.
module tb_incoming_ctx_pipe;
  localparam int FW = 4;
  localparam int SW = 32;
  localparam int WW = 9;
  localparam int TW = 32;
  localparam int CW = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  incoming_ctx_pipe_if #(.FLOW_ID_W(FW), .SEQ_W(SW), .TIMER_W(TW)) bus ();

  logic          cfg_we = 1'b0;
  logic [FW-1:0] cfg_flow_id = '0;
  logic [SW-1:0] cfg_wnd_start = '0;
  logic [WW-1:0] cfg_wnd_size = '0;
  logic [TW-1:0] cfg_timer = '0;
  logic [CW-1:0] cfg_ctx = '0;

  logic [SW-1:0] ul_cum_ack, ul_old_wnd_start, ul_wnd_start, ul_rtx_start, ul_rtx_end;
  logic [WW-1:0] ul_new_c_acks_cnt, ul_wnd_size, ul_wnd_size_out;
  logic [TW-1:0] ul_timer, ul_timer_out;
  logic [CW-1:0] ul_ctx, ul_ctx_out;
  logic          ul_mark_rtx, ul_reset_rtx_timer;
  logic [15:0]   stale_cnt;

  incoming_ctx_pipe dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_we(cfg_we), .cfg_flow_id(cfg_flow_id), .cfg_wnd_start(cfg_wnd_start),
    .cfg_wnd_size(cfg_wnd_size), .cfg_timer(cfg_timer), .cfg_ctx(cfg_ctx),
    .ul_cum_ack(ul_cum_ack), .ul_old_wnd_start(ul_old_wnd_start), .ul_wnd_start(ul_wnd_start),
    .ul_new_c_acks_cnt(ul_new_c_acks_cnt), .ul_wnd_size(ul_wnd_size), .ul_timer(ul_timer),
    .ul_ctx(ul_ctx), .ul_mark_rtx(ul_mark_rtx), .ul_reset_rtx_timer(ul_reset_rtx_timer),
    .ul_rtx_start(ul_rtx_start), .ul_rtx_end(ul_rtx_end), .ul_wnd_size_out(ul_wnd_size_out),
    .ul_timer_out(ul_timer_out), .ul_ctx_out(ul_ctx_out), .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  // Stub Reno: ctx counts consecutive duplicate ACKs, 3rd duplicate requests retransmit.
  logic          stub_dup;
  logic [CW-1:0] stub_ctx;
  always_comb begin
    stub_dup = (ul_new_c_acks_cnt == '0) && (ul_cum_ack == ul_old_wnd_start);
    stub_ctx = stub_dup ? ul_ctx + 36'd1 : '0;
  end
  assign ul_ctx_out         = stub_ctx;
  assign ul_mark_rtx        = stub_dup && (stub_ctx == 36'd3);
  assign ul_reset_rtx_timer = (ul_new_c_acks_cnt != '0);
  assign ul_rtx_start       = ul_wnd_start;
  assign ul_rtx_end         = ul_wnd_start + 32'd1;
  assign ul_wnd_size_out    = ul_wnd_size;
  assign ul_timer_out       = ul_timer;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [FW-1:0] f;
    logic          mark;
    logic          rst;
    logic [SW-1:0] rs;
    logic [SW-1:0] re;
    logic [TW-1:0] tmr;
  } res_t;

  logic [SW-1:0] m_start [16];
  logic [WW-1:0] m_size  [16];
  logic [TW-1:0] m_timer [16];
  logic [CW-1:0] m_ctx   [16];
  res_t          expq [$];
  logic          prev_stall = 1'b0;
  res_t          prev_snap;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_start[i] = '0; m_size[i] = 9'd1; m_timer[i] = '0; m_ctx[i] = '0;
    end
    expq.delete();
  endtask

  // Sequential reference: each accepted ACK fully resolves against the store in order.
  task automatic model_ev(input logic [FW-1:0] f, input logic [SW-1:0] a);
    logic [SW-1:0] s, d, ns;
    logic [WW-1:0] cnt;
    logic          dup;
    res_t          e;
    s = m_start[f];
    d = a - s;
    if ((a > s) && (d <= {23'd0, m_size[f]})) begin ns = a; cnt = d[WW-1:0]; end
    else begin ns = s; cnt = '0; end
    dup = (cnt == '0) && (a == s);
    m_ctx[f] = dup ? m_ctx[f] + 36'd1 : '0;
    e.f = f; e.mark = dup && (m_ctx[f] == 36'd3); e.rst = (cnt != '0);
    e.rs = ns; e.re = ns + 32'd1; e.tmr = m_timer[f];
    m_start[f] = ns;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    res_t cur, e;
    if (!rst_n) begin
      model_reset();
      prev_stall = 1'b0;
    end else begin
      cur = {bus.out_flow_id, bus.out_mark_rtx, bus.out_reset_rtx_timer,
             bus.out_rtx_start, bus.out_rtx_end, bus.out_timer};
      if (prev_stall) chk("out_hold_during_stall", cur, prev_snap);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = expq.pop_front();
          chk("result", cur, e);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_snap  = cur;
      if (cfg_we) begin
        m_start[cfg_flow_id] = cfg_wnd_start; m_size[cfg_flow_id] = cfg_wnd_size;
        m_timer[cfg_flow_id] = cfg_timer;     m_ctx[cfg_flow_id]  = cfg_ctx;
      end
      if (bus.in_valid && bus.in_ready) model_ev(bus.in_flow_id, bus.in_cum_ack);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [FW-1:0] f, input logic [SW-1:0] s, input logic [WW-1:0] z,
                     input logic [TW-1:0] t);
    cfg_we = 1'b1; cfg_flow_id = f; cfg_wnd_start = s; cfg_wnd_size = z;
    cfg_timer = t; cfg_ctx = '0;
    tick();
    cfg_we = 1'b0;
  endtask

  // Presents one ACK until accepted; returns in the cycle after acceptance (S1 cycle).
  task automatic push_ev(input logic [FW-1:0] f, input logic [SW-1:0] a);
    logic acc;
    int   g;
    bus.in_flow_id = f; bus.in_cum_ack = a; bus.in_valid = 1'b1;
    acc = 1'b0; g = 0;
    while (!acc && g < 50) begin
      @(negedge clk); acc = bus.in_ready;
      tick();
      g++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    int g;
    bus.in_valid = 1'b0; bus.in_flow_id = '0; bus.in_cum_ack = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_stale", stale_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", bus.in_ready, 1);

    // Basic advance
    cfg(4'd3, 32'd100, 9'd10, 32'd500);
    push_ev(4'd3, 32'd104);
    chk("basic_cnt", ul_new_c_acks_cnt, 4);
    chk("basic_new_start", ul_wnd_start, 104);
    chk("basic_old_start", ul_old_wnd_start, 100);
    chk("basic_not_yet_valid", bus.out_valid, 0);
    tick();
    chk("basic_valid_A2", bus.out_valid, 1);
    chk("basic_flow", bus.out_flow_id, 3);
    chk("basic_timer", bus.out_timer, 500);
    push_ev(4'd3, 32'd104);
    chk("store_updated", ul_old_wnd_start, 104);
    tick();

    // Duplicate ACKs
    cfg(4'd5, 32'd100, 9'd10, 32'd77);
    for (int k = 1; k <= 3; k++) begin
      push_ev(4'd5, 32'd100);
      chk("dup_cnt", ul_new_c_acks_cnt, 0);
      chk("dup_start", ul_wnd_start, 100);
      tick();
      chk("dup_mark", bus.out_mark_rtx, (k == 3));
    end
    chk("dup_rtx_start", bus.out_rtx_start, 100);
    chk("dup_rtx_end", bus.out_rtx_end, 101);

    // Out of window
    cfg(4'd6, 32'd100, 9'd10, 32'd0);
    push_ev(4'd6, 32'd200);
    chk("oow_hi_start", ul_wnd_start, 100);
    tick();
    chk("stale_one", stale_cnt, 1);
    push_ev(4'd6, 32'd50);
    chk("oow_lo_cnt", ul_new_c_acks_cnt, 0);
    tick();
    chk("stale_unchanged", stale_cnt, 1);

    // Back-to-back same flow
    cfg(4'd1, 32'd100, 9'd10, 32'd0);
    push_ev(4'd1, 32'd102);
    chk("b2b_first_cnt", ul_new_c_acks_cnt, 2);
    push_ev(4'd1, 32'd105);
    chk("b2b_fwd_old", ul_old_wnd_start, 102);
    chk("b2b_fwd_cnt", ul_new_c_acks_cnt, 3);
    repeat (2) tick();

    // Backpressure
    cfg(4'd4, 32'd0, 9'd100, 32'd0);
    bus.out_ready = 1'b0;
    fork
      begin
        push_ev(4'd4, 32'd10);
        push_ev(4'd4, 32'd20);
        push_ev(4'd4, 32'd30);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_first_result", bus.out_rtx_start, 10);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) tick();

    // cfg collides with S1 writeback of the same flow
    cfg(4'd2, 32'd100, 9'd10, 32'd0);
    push_ev(4'd2, 32'd105);
    cfg(4'd2, 32'd300, 9'd20, 32'd9);
    push_ev(4'd2, 32'd305);
    chk("cfg_wins_old", ul_old_wnd_start, 300);
    chk("cfg_wins_cnt", ul_new_c_acks_cnt, 5);
    tick();

    // Reset mid-stream
    push_ev(4'd2, 32'd310);
    tick();
    chk("pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", bus.out_valid, 0);
    chk("reset_async_flow", bus.out_flow_id, 0);
    chk("reset_async_stale", stale_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    push_ev(4'd2, 32'd1);
    chk("post_reset_old", ul_old_wnd_start, 0);
    chk("post_reset_size", ul_wnd_size, 1);
    chk("post_reset_cnt", ul_new_c_acks_cnt, 1);

    g = 0;
    while (expq.size() != 0 && g < 100) begin tick(); g++; end
    chk("drain_empty", expq.size(), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
